// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered CH-channel, N-bit multiplexer with manual or auto-scan selection.
// Latency: 1 clock from iDATA/iSEL to oDATA/oCH (manual and scan); nothing is reloaded while held.
// Backpressure: none; inputs are sampled every edge and iHOLD freezes index, dwell and output.
//
// Ports:
//   iCLK, iRST    clock, synchronous active-high reset
//   iDATA         flattened channels, channel k = iDATA[k*N +: N]
//   iSEL          manual channel select (values >= CH are ignored)
//   iMODE         0 = manual, 1 = auto-scan
//   iHOLD         freeze index, dwell counter and output
//   oDATA, oCH    registered selected data and its channel index (always aligned)
//   oSTB          one-cycle pulse in the cycle a new oCH first appears
module mux_nx1_scan #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int DWELL = 50_000_000,
  localparam int SW   = ($clog2(CH) > 1) ? $clog2(CH) : 1,
  localparam int CW   = $clog2(DWELL + 1)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [CH*N-1:0] iDATA,
  input  logic [SW-1:0]   iSEL,
  input  logic            iMODE,
  input  logic            iHOLD,
  output logic [N-1:0]    oDATA,
  output logic [SW-1:0]   oCH,
  output logic            oSTB
);

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [SW:0]   CH_W     = (SW+1)'(CH);
  localparam logic [SW-1:0] CH_LAST  = SW'(CH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [N-1:0]  r_data;
  logic [SW-1:0] r_ch;
  logic          r_stb;
  logic [CW-1:0] r_cnt;

  state_t        w_state;
  logic          w_sel_ok;
  logic          w_cnt_last;
  logic [SW-1:0] w_ch_inc;
  logic [SW-1:0] w_idx_n;
  logic [N-1:0]  w_data_n;

  // The mode is decoded from the inputs sampled on the same edge it acts on,
  // so a hold asserted on the advance cycle suppresses that advance.
  always_comb begin
    w_state = S_MAN;
    if (iHOLD)
      w_state = S_HOLD;
    else if (iMODE)
      w_state = S_SCAN;
  end

  always_comb begin
    w_sel_ok   = ({1'b0, iSEL} < CH_W);
    w_cnt_last = (r_cnt == CNT_LAST);
    w_ch_inc   = (r_ch == CH_LAST) ? '0 : r_ch + SW'(1);
    w_idx_n    = r_ch;
    case (w_state)
      S_MAN:   w_idx_n = w_sel_ok ? iSEL : r_ch;     // out-of-range select keeps the current channel
      S_SCAN:  w_idx_n = w_cnt_last ? w_ch_inc : r_ch;
      default: w_idx_n = r_ch;
    endcase
    w_data_n = iDATA[int'(w_idx_n)*N +: N];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_data <= '0;
      r_ch   <= '0;
      r_stb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_ch  <= w_idx_n;
      r_stb <= (w_idx_n != r_ch) && (w_state != S_HOLD);
      // Held output is not refreshed even if the source data moves underneath it.
      if (w_state != S_HOLD)
        r_data <= w_data_n;
      case (w_state)
        S_MAN:   r_cnt <= '0;
        S_SCAN:  r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign oDATA = r_data;
  assign oCH   = r_ch;
  assign oSTB  = r_stb;

endmodule

// File: tb/tb_mux_nx1_scan.sv
module tb_mux_nx1_scan;

  logic        iCLK;
  logic        iRST;
  logic [31:0] iDATA;
  logic [1:0]  iSEL;
  logic        iMODE;
  logic        iHOLD;

  logic [7:0]  oDATA,  oDATA3,  oDATA1;
  logic [1:0]  oCH,    oCH3,    oCH1;
  logic        oSTB,   oSTB3,   oSTB1;

  int checks = 0;
  int errors = 0;

  // Main instance: CH=4, DWELL=3
  mux_nx1_scan #(.N(8), .CH(4), .DWELL(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iSEL(iSEL), .iMODE(iMODE),
    .iHOLD(iHOLD), .oDATA(oDATA), .oCH(oCH), .oSTB(oSTB)
  );

  // Three-channel instance for the out-of-range select case
  mux_nx1_scan #(.N(8), .CH(3), .DWELL(3)) dut3 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA[23:0]), .iSEL(iSEL), .iMODE(iMODE),
    .iHOLD(iHOLD), .oDATA(oDATA3), .oCH(oCH3), .oSTB(oSTB3)
  );

  // DWELL=1 instance: advances every scan edge
  mux_nx1_scan #(.N(8), .CH(4), .DWELL(1)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iSEL(iSEL), .iMODE(iMODE),
    .iHOLD(iHOLD), .oDATA(oDATA1), .oCH(oCH1), .oSTB(oSTB1)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Advance one edge and sample 1 time unit after it.
  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset;
    iRST = 1'b1; iDATA = 32'hDDCCBBAA; iSEL = 2'd0; iMODE = 1'b0; iHOLD = 1'b0;
    tick(); tick();
    if (oDATA !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", oDATA); end
    checks++;
    if (oCH !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", oCH); end
    checks++;
    if (oSTB !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", oSTB); end
    checks++;
    iRST = 1'b0;
    tick();
    if (oDATA !== 8'hAA) begin errors++; $display("FAIL post_reset_data got %h exp aa", oDATA); end
    checks++;
    if (oSTB !== 1'b0) begin errors++; $display("FAIL post_reset_stb got %b exp 0", oSTB); end
    checks++;
  endtask

  task automatic test_manual;
    logic [1:0] sel_v [3] = '{2'd2, 2'd2, 2'd3};
    logic [1:0] ch_e  [3] = '{2'd2, 2'd2, 2'd3};
    logic [7:0] dat_e [3] = '{8'hCC, 8'hCC, 8'hDD};
    logic       stb_e [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      iSEL = sel_v[i];
      tick();
      if ({oCH, oDATA, oSTB} !== {ch_e[i], dat_e[i], stb_e[i]}) begin
        errors++;
        $display("FAIL manual[%0d] got ch=%0d data=%h stb=%b exp ch=%0d data=%h stb=%b",
                 i, oCH, oDATA, oSTB, ch_e[i], dat_e[i], stb_e[i]);
      end
      checks++;
    end
  endtask

  task automatic test_scan_wrap;
    logic [1:0] ch_e  [9] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       stb_e [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] d;
    logic [7:0]  de;
    iSEL = 2'd2;
    tick();
    if (oCH !== 2'd2) begin errors++; $display("FAIL scan_start_ch got %0d exp 2", oCH); end
    checks++;
    iMODE = 1'b1;
    d = iDATA;
    for (int i = 0; i < 9; i++) begin
      tick();
      de = d[ch_e[i]*8 +: 8];
      if ({oCH, oDATA, oSTB} !== {ch_e[i], de, stb_e[i]}) begin
        errors++;
        $display("FAIL scan[%0d] got ch=%0d data=%h stb=%b exp ch=%0d data=%h stb=%b",
                 i, oCH, oDATA, oSTB, ch_e[i], de, stb_e[i]);
      end
      checks++;
    end
  endtask

  // Continues from the scan: oCH=1 with counter 0.
  task automatic test_hold;
    tick(); tick();   // counter now at DWELL-1, oCH still 1
    if (oCH !== 2'd1) begin errors++; $display("FAIL hold_pre_ch got %0d exp 1", oCH); end
    checks++;
    iHOLD = 1'b1;
    iDATA = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({oCH, oDATA, oSTB} !== {2'd1, 8'hBB, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d] got ch=%0d data=%h stb=%b exp ch=1 data=bb stb=0",
                 i, oCH, oDATA, oSTB);
      end
      checks++;
    end
    iHOLD = 1'b0;
    tick();
    if ({oCH, oDATA, oSTB} !== {2'd2, 8'h33, 1'b1}) begin
      errors++;
      $display("FAIL hold_release got ch=%0d data=%h stb=%b exp ch=2 data=33 stb=1", oCH, oDATA, oSTB);
    end
    checks++;
    tick();
    if ({oCH, oSTB} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL hold_after got ch=%0d stb=%b exp ch=2 stb=0", oCH, oSTB);
    end
    checks++;
    iDATA = 32'hDDCCBBAA;
  endtask

  task automatic test_invalid_sel;
    iMODE = 1'b0;
    iSEL  = 2'd2;
    tick();
    if (oCH3 !== 2'd2) begin errors++; $display("FAIL inv_pre_ch got %0d exp 2", oCH3); end
    checks++;
    iSEL = 2'd3;
    tick();
    if ({oCH3, oDATA3, oSTB3} !== {2'd2, 8'hCC, 1'b0}) begin
      errors++;
      $display("FAIL inv_sel3 got ch=%0d data=%h stb=%b exp ch=2 data=cc stb=0", oCH3, oDATA3, oSTB3);
    end
    checks++;
    iSEL = 2'd1;
    tick();
    if ({oCH3, oDATA3, oSTB3} !== {2'd1, 8'hBB, 1'b1}) begin
      errors++;
      $display("FAIL inv_sel1 got ch=%0d data=%h stb=%b exp ch=1 data=bb stb=1", oCH3, oDATA3, oSTB3);
    end
    checks++;
  endtask

  task automatic test_reset_mid_scan;
    logic [1:0] ch_e  [3] = '{2'd0, 2'd0, 2'd1};
    logic [7:0] dat_e [3] = '{8'hAA, 8'hAA, 8'hBB};
    logic       stb_e [3] = '{1'b0, 1'b0, 1'b1};
    iMODE = 1'b0; iSEL = 2'd1;
    tick();
    iMODE = 1'b1;
    tick();           // oCH=1, counter=1
    if (oCH !== 2'd1) begin errors++; $display("FAIL rms_pre_ch got %0d exp 1", oCH); end
    checks++;
    iRST = 1'b1;
    tick();
    if ({oCH, oDATA, oSTB} !== {2'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rms_reset got ch=%0d data=%h stb=%b exp ch=0 data=00 stb=0", oCH, oDATA, oSTB);
    end
    checks++;
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({oCH, oDATA, oSTB} !== {ch_e[i], dat_e[i], stb_e[i]}) begin
        errors++;
        $display("FAIL rms[%0d] got ch=%0d data=%h stb=%b exp ch=%0d data=%h stb=%b",
                 i, oCH, oDATA, oSTB, ch_e[i], dat_e[i], stb_e[i]);
      end
      checks++;
    end
  endtask

  task automatic test_dwell_one;
    logic [1:0] ch_e  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] dat_e [5] = '{8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB};
    iRST = 1'b1; iMODE = 1'b1; iHOLD = 1'b0;
    tick();
    iRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({oCH1, oDATA1, oSTB1} !== {ch_e[i], dat_e[i], 1'b1}) begin
        errors++;
        $display("FAIL dwell1[%0d] got ch=%0d data=%h stb=%b exp ch=%0d data=%h stb=1",
                 i, oCH1, oDATA1, oSTB1, ch_e[i], dat_e[i]);
      end
      checks++;
    end
    iMODE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_invalid_sel();
    test_reset_mid_scan();
    test_dwell_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
